// File: rtl/freq_counter_mc.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_mc
// Purpose  : Multi-channel gated rising-edge counter with saturating results,
//            per-channel overflow flags and a registered channel-select read port.
// Revision : 1.0 - initial release
// ============================================================================
module freq_counter_mc #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_CH-1:0]   sig_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              done,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic [N_CH-1:0]   ovf_flags
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_arm   = 2'd1;
    localparam logic [1:0] c_st_gate  = 2'd2;
    localparam logic [1:0] c_st_latch = 2'd3;
    localparam int         c_n_sel    = 2 ** SEL_W;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              w_load;
    logic [GATE_W-1:0] r_timer;
    logic [N_CH-1:0]   r_sync [SYNC_STAGES];
    logic [N_CH-1:0]   r_prev;
    logic [N_CH-1:0]   r_edge;
    logic [CNT_W-1:0]  r_cnt [N_CH];
    logic [N_CH-1:0]   r_wovf;
    logic [CNT_W-1:0]  r_res [N_CH];
    logic [N_CH-1:0]   r_ovf_flags;
    logic              r_done;
    logic [CNT_W-1:0]  r_rd_data;
    logic              r_rd_ovf;
    logic [CNT_W-1:0]  w_res_pad [c_n_sel];
    logic [c_n_sel-1:0] w_ovf_pad;

    // Synchroniser chain followed by a registered rising-edge detector
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_sync[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            c_st_idle: begin
                if ((start || continuous) && (gate_len != '0)) begin
                    w_next = c_st_arm;
                    w_load = 1'b1;
                end
            end
            c_st_arm:  w_next = c_st_gate;
            c_st_gate: begin
                if (r_timer == GATE_W'(1)) w_next = c_st_latch;
            end
            c_st_latch: begin
                if (continuous && (gate_len != '0)) begin
                    w_next = c_st_arm;
                    w_load = 1'b1;
                end else begin
                    w_next = c_st_idle;
                end
            end
            default:   w_next = c_st_idle;
        endcase
    end

    // Timer is captured on the edge that enters ARM so gate_len is sampled once per window
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= c_st_idle;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_timer <= gate_len;
            end else if (r_state == c_st_gate) begin
                r_timer <= r_timer - GATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
                r_res[i] <= '0;
            end
            r_wovf      <= '0;
            r_ovf_flags <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_latch);
            if (r_state == c_st_arm) begin
                for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
                r_wovf <= '0;
            end else if (r_state == c_st_gate) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (r_edge[i]) begin
                        if (&r_cnt[i]) r_wovf[i] <= 1'b1;
                        else           r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
            if (r_state == c_st_latch) begin
                for (int i = 0; i < N_CH; i++) r_res[i] <= r_cnt[i];
                r_ovf_flags <= r_wovf;
            end
        end
    end

    // Pad the result set to the full select range so unused selects read as zero
    generate
        for (genvar g = 0; g < c_n_sel; g++) begin : g_pad
            if (g < N_CH) begin : g_ch
                assign w_res_pad[g] = r_res[g];
                assign w_ovf_pad[g] = r_ovf_flags[g];
            end else begin : g_zero
                assign w_res_pad[g] = '0;
                assign w_ovf_pad[g] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            r_rd_data <= w_res_pad[rd_sel];
            r_rd_ovf  <= w_ovf_pad[rd_sel];
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign done      = r_done;
    assign rd_data   = r_rd_data;
    assign rd_ovf    = r_rd_ovf;
    assign ovf_flags = r_ovf_flags;

endmodule
`default_nettype wire

// File: tb/tb_freq_counter_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_counter_mc
// Purpose  : Scoreboard bench for freq_counter_mc using an edge-timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_counter_mc;

    localparam int N_CH   = 3;
    localparam int CNT_W  = 8;
    localparam int GATE_W = 16;
    localparam int SYNC   = 2;
    localparam int SEL_W  = 2;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic [N_CH-1:0]   sig_in = '0;
    logic [GATE_W-1:0] gate_len = '0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              busy;
    logic              done;
    logic [SEL_W-1:0]  rd_sel = '0;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_ovf;
    logic [N_CH-1:0]   ovf_flags;

    freq_counter_mc #(
        .N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SYNC), .SEL_W(SEL_W)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .sig_in(sig_in), .gate_len(gate_len),
        .start(start), .continuous(continuous), .busy(busy), .done(done), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_ovf(rd_ovf), .ovf_flags(ovf_flags)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        bit              busy;
        bit              done;
        int              rd_data;
        bit              rd_ovf;
        int              ovf;
    } exp_t;

    exp_t            exp_q[$];
    logic [N_CH-1:0] hist[$];
    int              cyc = -1;
    int              checks = 0;
    int              errors = 0;
    int              per [N_CH] = '{default: 0};
    int              ph  [N_CH] = '{default: 0};

    // Signal generator: per>0 periodic square wave, per<0 random bits, per==0 held low
    always @(negedge clk_clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            ph[ch] = ph[ch] + 1;
            if (per[ch] > 0)      sig_in[ch] = (ph[ch] % per[ch]) < (per[ch] / 2);
            else if (per[ch] < 0) sig_in[ch] = 1'($urandom_range(0, 1));
            else                  sig_in[ch] = 1'b0;
        end
        rd_sel = SEL_W'($urandom_range(0, 3));
    end

    // Reference model: windows tracked by cycle numbers, counts from sampled-edge timestamps
    bit          m_active = 0;
    int          m_arm = 0;
    int          m_len = 0;
    int          vis_res [N_CH] = '{default: 0};
    bit          vis_ovf [N_CH] = '{default: 0};

    always @(posedge clk_clk) begin : p_model
        exp_t e;
        int   sel;
        int   raw;
        int   ovf_vec;
        bit   dn;
        cyc = cyc + 1;
        sel = int'(rd_sel);
        hist.push_back(reset_reset ? '0 : sig_in);
        dn = 0;
        e.rd_data = (!reset_reset && sel < N_CH) ? vis_res[sel] : 0;
        e.rd_ovf  = (!reset_reset && sel < N_CH) ? vis_ovf[sel] : 1'b0;
        if (reset_reset) begin
            m_active = 0;
            for (int ch = 0; ch < N_CH; ch++) begin
                vis_res[ch] = 0;
                vis_ovf[ch] = 0;
            end
        end else if (m_active && cyc == m_arm + m_len + 2) begin
            // An edge seen at sample p is counted if its pulse (p+SYNC) lands in a gate cycle
            for (int ch = 0; ch < N_CH; ch++) begin
                raw = 0;
                for (int p = m_arm + 1 - SYNC; p <= m_arm + m_len - SYNC; p++)
                    if (hist[p][ch] && !hist[p-1][ch]) raw++;
                vis_res[ch] = (raw > SAT) ? SAT : raw;
                vis_ovf[ch] = (raw > SAT);
            end
            dn = 1;
            if (continuous && gate_len != 0) begin
                m_arm = cyc;
                m_len = int'(gate_len);
            end else begin
                m_active = 0;
            end
        end else if (!m_active && (start || continuous) && gate_len != 0) begin
            m_active = 1;
            m_arm    = cyc;
            m_len    = int'(gate_len);
        end
        ovf_vec = 0;
        for (int ch = 0; ch < N_CH; ch++) if (vis_ovf[ch]) ovf_vec |= (1 << ch);
        e.busy = m_active && (cyc <= m_arm + m_len + 1);
        e.done = dn;
        e.ovf  = ovf_vec;
        exp_q.push_back(e);
    end

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk_clk) begin : p_monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            chk("rd_data", int'(rd_data), e.rd_data);
            chk("rd_ovf", int'(rd_ovf), int'(e.rd_ovf));
            chk("ovf_flags", int'(ovf_flags), e.ovf);
        end
    end

    task automatic cyc_n(int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_clk);
            if (done) break;
        end
    endtask

    initial begin
        cyc_n(4);
        reset_reset = 1'b0;
        cyc_n(5);

        // Single-shot basic count on ch0
        per = '{10, 0, 0};
        gate_len = 16'd1000;
        cyc_n(20);
        pulse_start();
        cyc_n(1010);

        // Saturation on ch1
        per = '{0, 2, 0};
        pulse_start();
        cyc_n(1010);

        // Continuous windows with a rate change and a mid-window stop
        per = '{0, 0, 5};
        gate_len = 16'd500;
        continuous = 1'b1;
        repeat (3) wait_done(600);
        per[2] = 25;
        repeat (2) wait_done(600);
        cyc_n(200);
        continuous = 1'b0;
        cyc_n(700);

        // Reset in the middle of a gate, then a clean window
        per = '{10, 3, 7};
        gate_len = 16'd1000;
        pulse_start();
        cyc_n(400);
        reset_reset = 1'b1;
        cyc_n(1);
        reset_reset = 1'b0;
        cyc_n(10);
        pulse_start();
        cyc_n(1010);

        // Zero-length gate is ignored in both trigger modes
        gate_len = '0;
        pulse_start();
        cyc_n(10);
        continuous = 1'b1;
        cyc_n(10);
        continuous = 1'b0;
        cyc_n(5);

        // Extra starts while busy, then a gate_len change mid-gate
        gate_len = 16'd300;
        pulse_start();
        cyc_n(50);
        pulse_start();
        cyc_n(100);
        pulse_start();
        cyc_n(200);
        gate_len = 16'd200;
        pulse_start();
        cyc_n(50);
        gate_len = 16'd7;
        cyc_n(200);

        // Shortest gates
        gate_len = 16'd1;
        pulse_start();
        cyc_n(10);
        gate_len = 16'd2;
        pulse_start();
        cyc_n(10);

        // Randomised traffic
        for (int it = 0; it < 6000; it++) begin
            if (it % 600 == 0)
                for (int ch = 0; ch < N_CH; ch++)
                    case ($urandom_range(0, 3))
                        0:       per[ch] = 0;
                        1:       per[ch] = -1;
                        default: per[ch] = int'($urandom_range(2, 30));
                    endcase
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 9))
                    0:       gate_len = '0;
                    1:       gate_len = GATE_W'($urandom_range(1, 3));
                    2:       gate_len = GATE_W'($urandom_range(600, 1200));
                    default: gate_len = GATE_W'($urandom_range(1, 300));
                endcase
            end
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 399) == 0) continuous = ~continuous;
            reset_reset = ($urandom_range(0, 2999) == 0);
            @(negedge clk_clk);
        end
        start = 1'b0;
        continuous = 1'b0;
        reset_reset = 1'b0;
        cyc_n(1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
